sbox_layer_serial: RTL and testbench
====================================

// Module: sbox_layer_serial
// PURPOSE
//  Serial substitution-layer driver for the 6-bit power-map S-box datapath.
//  Accepts a packed state of NWORDS 6-bit words over a valid/ready handshake.
//  Streams each word through one external combinational 6-bit S-box, one word per cycle.
//  Writes each result back in place, then presents the substituted state downstream.
//  Sits between the round-key adder (upstream) and the linear diffusion layer (downstream).
// PARAMETERS
//  NWORDS  6  number of 6-bit words per state; supported range 2..16; state width = 6*NWORDS
// PORTS
//  clk        in   1          single clock; all flops update on the rising edge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          upstream state valid
//  in_ready   out  1          block can accept a state
//  in_data    in   6*NWORDS   state; word k = in_data[6k+5:6k]
//  out_valid  out  1          substituted state valid
//  out_ready  in   1          downstream accepts the state
//  out_data   out  6*NWORDS   substituted state, same word packing as in_data
//  sb_x       out  6          word presented to the external S-box
//  sb_y       in   6          S-box result; combinational function of sb_x, zero latency
//  busy       out  1          high in RUN or DONE
// BEHAVIOUR
//  Reset (rst=1 at a clock edge):
//   - state goes to IDLE; counter = 0; state register = 0.
//   - in_ready=1; out_valid=0; out_data=0; sb_x=0; busy=0.
//   - rst overrides every other input in the same cycle.
//   - A reset during RUN or DONE discards the state; nothing is emitted.
//  FSM states IDLE, RUN, DONE:
//   - IDLE: in_ready=1. On in_valid=1, capture in_data, clear counter, go to RUN.
//   - RUN: in_ready=0. sb_x = word[cnt]. At the edge, word[cnt] <= sb_y and cnt increments.
//     Words are processed LSW first (word 0 first).
//     After the word[NWORDS-1] write, go to DONE. cnt is $clog2(NWORDS+1) bits.
//   - DONE: out_valid=1. out_data holds the register and stays stable while out_ready=0.
//     On out_ready=1, go to IDLE.
//  Handshake rules:
//   - A transfer occurs when valid and ready are both high at an edge.
//   - in_ready is low in DONE, so a new accept cannot coincide with the out transfer.
//     Minimum period is NWORDS+2 cycles.
//  Latency: the accept edge is E. out_valid is high from the cycle after edge E+NWORDS.
//   For NWORDS=6 that is 7 cycles after the accept cycle.
//  Outside RUN, sb_x=0 and sb_y is ignored.
//  in_data is sampled only at the accept edge; later changes have no effect.
// CONFIGURATION
//  SBOX_LAYER_SB_REG_EN defined:
//   - sb_y is registered before write-back to cut the external S-box timing path.
//   - RUN lasts NWORDS+1 cycles. Cycle k drives sb_x=word[k] (0 when k=NWORDS).
//     Cycle k writes word[k-1] from the registered sb_y (no write at k=0).
//   - Latency is +1 cycle; period is NWORDS+3.
//   - The sb_y register resets to 0.
//  SBOX_LAYER_SB_REG_EN undefined: direct write-back, timing exactly as in BEHAVIOUR.
// TESTING (NWORDS=6; bench S-box stub sb_y = sb_x ^ 6'h15)
//  1 Basic: in_data=36'h000000000 -> out_data=36'h555555555.
//    out_valid is high 7 cycles after the accept; busy is high throughout.
//  2 Word order: in_data=36'h000000001 -> sb_x sequence 01,00,00,00,00,00.
//    out_data=36'h555555554.
//  3 All ones: in_data=36'hFFFFFFFFF -> out_data=36'hAAAAAAAAA.
//    in_ready stays 0 until the out transfer.
//  4 Backpressure: out_ready=0 for 10 cycles in DONE.
//    out_valid=1 and out_data stay constant; in_valid=1 is not accepted.
//    Raising out_ready gives one transfer, then IDLE with in_ready=1 the next cycle.
//  5 Reset mid-RUN: assert rst at cnt=3.
//    Next cycle: IDLE, out_valid=0, out_data=0, sb_x=0, in_ready=1; no output is produced.
//  6 With SBOX_LAYER_SB_REG_EN: rerun scenarios 1-2.
//    Same out_data; out_valid arrives 8 cycles after the accept.
//    sb_x sequence is 01,00,00,00,00,00,00.

Source files
------------

// File: rtl/sbox_layer_serial.sv
// Serial substitution layer: one 6-bit word per cycle goes through an external S-box and is written back in place.
// Optional macro SBOX_LAYER_SB_REG_EN registers sb_y before write-back (adds one RUN cycle).
`timescale 1ns/1ps

module sbox_layer_serial #(
    parameter int NWORDS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6*NWORDS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6*NWORDS-1:0]   out_data,
    output logic [5:0]            sb_x,
    input  logic [5:0]            sb_y,
    output logic                  busy
);

    localparam int CW = $clog2(NWORDS + 1);

`ifdef SBOX_LAYER_SB_REG_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [5:0]    word_q [NWORDS];
    logic [5:0]    word_sel;

`ifdef SBOX_LAYER_SB_REG_EN
    logic [5:0]    sb_y_q;
`endif

    // Loop-compare mux keeps the index width independent of the array size.
    always_comb begin
        word_sel = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (cnt_q == CW'(i)) begin
                word_sel = word_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        sb_x      = '0;
        out_data  = '0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            RUN: begin
                busy = 1'b1;
                sb_x = word_sel;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                for (int unsigned i = 0; i < NWORDS; i++) begin
                    out_data[6*i +: 6] = word_q[i];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int unsigned i = 0; i < NWORDS; i++) begin
                word_q[i] <= '0;
            end
`ifdef SBOX_LAYER_SB_REG_EN
            sb_y_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cnt_q <= '0;
                        for (int unsigned i = 0; i < NWORDS; i++) begin
                            word_q[i] <= in_data[6*i +: 6];
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
`ifdef SBOX_LAYER_SB_REG_EN
                    // Write-back trails the S-box drive by one cycle; count 0 has nothing to write.
                    sb_y_q <= sb_y;
                    for (int unsigned i = 0; i < NWORDS; i++) begin
                        if (cnt_q == CW'(i + 1)) begin
                            word_q[i] <= sb_y_q;
                        end
                    end
`else
                    for (int unsigned i = 0; i < NWORDS; i++) begin
                        if (cnt_q == CW'(i)) begin
                            word_q[i] <= sb_y;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_layer_serial.sv
// Self-checking bench for sbox_layer_serial with an XOR-0x15 S-box stub and a word-level reference model.
`timescale 1ns/1ps

module tb_sbox_layer_serial;

    localparam int NW = 6;
    localparam int W  = 6 * NW;
`ifdef SBOX_LAYER_SB_REG_EN
    localparam int RUN_LEN = NW + 1;
`else
    localparam int RUN_LEN = NW;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [5:0]   sb_x;
    logic [5:0]   sb_y;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sb_y = sb_x ^ 6'h15;

    sbox_layer_serial #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sb_x      (sb_x),
        .sb_y      (sb_y),
        .busy      (busy)
    );

    function automatic logic [W-1:0] ref_layer(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int k = 0; k < NW; k++) r[6*k +: 6] = d[6*k +: 6] ^ 6'h15;
        return r;
    endfunction

    function automatic logic [5:0] ref_sbx(input logic [W-1:0] d, input int k);
        if (k < NW) return d[6*k +: 6];
        return 6'h00;
    endfunction

    function automatic logic [W-1:0] rand_state();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic transact(input logic [W-1:0] d, input int stall, input string name);
        logic [W-1:0] exp_out;
        exp_out = ref_layer(d);
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL %s idle_before: ready,busy=%b want 10", name, {in_ready, busy});
        end
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b0;
        tick();
        in_data = rand_state();
        for (int k = 0; k < RUN_LEN; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            checks++;
            if (sb_x !== ref_sbx(d, k)) begin
                errors++;
                $display("FAIL %s sb_x step %0d: got %h want %h", name, k, sb_x, ref_sbx(d, k));
            end
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b001) begin
                errors++;
                $display("FAIL %s run_flags step %0d: valid,ready,busy=%b want 001", name, k,
                         {out_valid, in_ready, busy});
            end
            tick();
        end
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b101) begin
            errors++;
            $display("FAIL %s done_flags: valid,ready,busy=%b want 101", name, {out_valid, in_ready, busy});
        end
        checks++;
        if (out_data !== exp_out) begin
            errors++;
            $display("FAIL %s out_data: got %h want %h", name, out_data, exp_out);
        end
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = rand_state();
            tick();
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || out_data !== exp_out) begin
                errors++;
                $display("FAIL %s stall %0d: valid,ready=%b data %h want 10 data %h", name, s,
                         {out_valid, in_ready}, out_data, exp_out);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rand_state();
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010 || sb_x !== 6'h00 || out_data !== '0) begin
            errors++;
            $display("FAIL %s after_xfer: valid,ready,busy=%b sb_x %h data %h want 010 00 0", name,
                     {out_valid, in_ready, busy}, sb_x, out_data);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = rand_state();
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0 || sb_x !== 6'h00) begin
            errors++;
            $display("FAIL reset_state: ready,valid,busy=%b data %h sb_x %h want 100 0 00",
                     {in_ready, out_valid, busy}, out_data, sb_x);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: ready,busy=%b want 10", {in_ready, busy});
        end
    endtask

    task automatic test_directed();
        transact(36'h000000000, 0, "basic_zero");
        transact(36'h000000001, 0, "word_order");
        transact(36'hFFFFFFFFF, 2, "all_ones");
    endtask

    task automatic test_backpressure();
        transact(rand_state(), 10, "backpressure");
    endtask

    task automatic test_reset_mid_run();
        in_valid = 1'b1;
        in_data  = rand_state();
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== '0 || sb_x !== 6'h00) begin
            errors++;
            $display("FAIL midrun_reset: ready,valid,busy=%b data %h sb_x %h want 100 0 00",
                     {in_ready, out_valid, busy}, out_data, sb_x);
        end
        for (int k = 0; k < NW + 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrun_no_output cycle %0d: valid %b busy %b want 0 0", k, out_valid, busy);
            end
        end
        transact(rand_state(), 0, "midrun_recover");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            transact(rand_state(), int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) transact(rand_state(), 0, "back_to_back");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
